spi_slave_listener: RTL

SPI slave receiver that accepts 24-bit command words from the external host controller and presents them to the control FSM as `fpga_spi_data` with a one-cycle `spi_listener_interrupt` strobe. It is the responder end of the host-to-FPGA SPI link, oversampling SCLK/CS/MOSI in the `clk` domain. Optionally, it shifts a 24-bit status word back on MISO during the same frame.

---
 rtl/spi_if.sv | 11 +
 rtl/spi_slave_listener.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/spi_if.sv
// SPI pin bundle between an external host (master) and the FPGA listener (slave).
interface spi_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output cs_n, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_slave_listener.sv
// Oversampled SPI mode-0 slave receiving DATA_WIDTH-bit command words.
// Optional MISO status readback is built when SPI_LISTENER_READBACK_EN is defined.
//
// state     | meaning
// WAIT_IDLE | after reset: let synchronizers fill, then wait for cs_n high
// IDLE      | deselected, waiting for a cs_n fall to start a frame
// SHIFT     | selected, shifting bits until cs_n rises
module spi_slave_listener #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_if.slave                  bus,
  input  logic [DATA_WIDTH-1:0] tx_word,
  output logic [DATA_WIDTH-1:0] fpga_spi_data,
  output logic                  spi_listener_interrupt,
  output logic                  frame_error
);

  localparam int CW = $clog2(DATA_WIDTH + 2);
  localparam int SW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_WIDTH + 1);
  localparam logic [SW-1:0] SETTLE   = SW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
  logic                   sclk_prev, cs_prev, mosi_prev;
  logic                   sclk_s, cs_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t                 state;
  logic [SW-1:0]          settle;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]  rx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sr   <= '0;
      cs_sr     <= '1;
      mosi_sr   <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      mosi_prev <= 1'b0;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], bus.sclk};
      cs_sr     <= {cs_sr[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev <= sclk_sr[SYNC_STAGES-1];
      cs_prev   <= cs_sr[SYNC_STAGES-1];
      mosi_prev <= mosi_sr[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign cs_s      = cs_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

`ifdef SPI_LISTENER_READBACK_EN
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  miso_q;
  logic                  miso_oe_q;
  assign bus.miso    = miso_q;
  assign bus.miso_oe = miso_oe_q;
`else
  logic unused_tx;
  assign unused_tx   = ^tx_word;
  assign bus.miso    = 1'b0;
  assign bus.miso_oe = 1'b0;
`endif

  // mosi_prev is aligned with sclk_prev, so it is the bit present just before the rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= WAIT_IDLE;
      settle                 <= SETTLE;
      bit_cnt                <= '0;
      rx_shift               <= '0;
      fpga_spi_data          <= '0;
      spi_listener_interrupt <= 1'b0;
      frame_error            <= 1'b0;
`ifdef SPI_LISTENER_READBACK_EN
      tx_shift               <= '0;
      miso_q                 <= 1'b0;
      miso_oe_q              <= 1'b0;
`endif
    end else begin
      spi_listener_interrupt <= 1'b0;
      frame_error            <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          // Synchronizers reset to cs_n=1, so hold off until real pin data arrives.
          if (settle != '0) settle <= settle - 1'b1;
          else if (cs_s && cs_prev) state <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
`ifdef SPI_LISTENER_READBACK_EN
            tx_shift  <= tx_word;
            miso_q    <= tx_word[DATA_WIDTH-1];
            miso_oe_q <= 1'b1;
`endif
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            if (bit_cnt == CNT_FULL) begin
              fpga_spi_data          <= rx_shift;
              spi_listener_interrupt <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
`ifdef SPI_LISTENER_READBACK_EN
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
`endif
            state <= IDLE;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_prev};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
          end else if (sclk_fall) begin
`ifdef SPI_LISTENER_READBACK_EN
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            miso_q   <= tx_shift[DATA_WIDTH-2];
`endif
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule
